// File: rtl/boot_rom_pkg.sv
// Shared types and constants for the boot ROM loader.
package boot_rom_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Legal range of the read latency parameter.
  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 2;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
module bram_sdp #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Array write; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; holds its value when no read is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/boot_rom_6502.sv
// Loadable boot ROM: an image is streamed in, then the ROM locks and serves reads.
module boot_rom_6502
  import boot_rom_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_oe,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_q,
  input  logic              ld_start,
  input  logic              ld_wr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              locked,
  output logic [15:0]       ld_sum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  // Any latency above the minimum selects the two-stage read path.
  localparam bit LAT2 = (READ_LAT > READ_LAT_MIN);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [15:0]       r_sum;
  logic              r_ld_done;
  logic              r_vld1;
  logic              w_start_load;
  logic              w_accept;
  logic              w_last;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_ram_q;

  // ld_start restarts from IDLE or LOAD; a coincident ld_wr is dropped.
  assign w_start_load = ld_start && (r_state != LOCKED);
  assign w_accept     = (r_state == LOAD) && ld_wr && !ld_start;
  assign w_last       = w_accept && (r_wr_ptr == LAST_ADDR);
  assign w_rd_en      = cpu_oe && (r_state == LOCKED);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ld_start) w_next = LOAD;
      LOAD:    if (w_last)   w_next = LOCKED;
      LOCKED:  w_next = LOCKED;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    locked   = (r_state == LOCKED);
    ld_ready = (r_state == LOAD);
  end

  // Load pointer, running checksum and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_sum     <= '0;
      r_ld_done <= 1'b0;
    end else begin
      r_ld_done <= w_last;
      if (w_start_load) begin
        r_wr_ptr <= '0;
        r_sum    <= '0;
      end else if (w_accept) begin
        r_sum <= r_sum + 16'(ld_data);
        if (!w_last) r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  assign ld_done = r_ld_done;
  assign ld_sum  = r_sum;

  bram_sdp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (ld_data),
    .i_re    (w_rd_en),
    .i_raddr (cpu_addr),
    .o_rdata (w_ram_q)
  );

  // First read-valid stage, aligned with the RAM output register.
  always_ff @(posedge clk) begin
    if (reset) r_vld1 <= 1'b0;
    else       r_vld1 <= w_rd_en;
  end

  if (LAT2) begin : g_lat2
    logic              r_vld2;
    logic [DATA_W-1:0] r_q2;

    // Second read stage; data only advances with a valid word.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld2 <= 1'b0;
        r_q2   <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) r_q2 <= w_ram_q;
      end
    end

    assign cpu_valid = r_vld2;
    assign cpu_q     = r_q2;
  end else begin : g_lat1
    assign cpu_valid = r_vld1;
    assign cpu_q     = w_ram_q;
  end

endmodule

// File: tb/tb_boot_rom_6502.sv
// Directed bench for boot_rom_6502, with READ_LAT = 1 and READ_LAT = 2 instances.
module tb_boot_rom_6502;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] cpu_addr;
  logic        cpu_oe;
  logic        ld_start;
  logic        ld_wr;
  logic [7:0]  ld_data;

  logic        v1, v2;
  logic [7:0]  q1, q2;
  logic        rdy1, rdy2, done1, done2, lk1, lk2;
  logic [15:0] sum1, sum2;

  int n_vec  = 0;
  int n_fail = 0;
  int done_cnt;

  always #5 clk = ~clk;

  boot_rom_6502 #(.ADDR_W(12), .DATA_W(8), .READ_LAT(1)) u_d1 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_oe(cpu_oe),
    .cpu_valid(v1), .cpu_q(q1), .ld_start(ld_start), .ld_wr(ld_wr),
    .ld_data(ld_data), .ld_ready(rdy1), .ld_done(done1), .locked(lk1),
    .ld_sum(sum1)
  );

  boot_rom_6502 #(.ADDR_W(12), .DATA_W(8), .READ_LAT(2)) u_d2 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_oe(cpu_oe),
    .cpu_valid(v2), .cpu_q(q2), .ld_start(ld_start), .ld_wr(ld_wr),
    .ld_data(ld_data), .ld_ready(rdy2), .ld_done(done2), .locked(lk2),
    .ld_sum(sum2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cpu_oe = 1'b0; cpu_addr = '0;
    ld_start = 1'b0; ld_wr = 1'b0; ld_data = '0;
    tick; tick;

    // Reset state
    chk("rst_v1",   32'(v1),    0); chk("rst_v2",   32'(v2),    0);
    chk("rst_q1",   32'(q1),    0); chk("rst_q2",   32'(q2),    0);
    chk("rst_lk",   32'(lk1),   0); chk("rst_rdy",  32'(rdy1),  0);
    chk("rst_done", 32'(done1), 0); chk("rst_sum",  32'(sum1),  0);
    reset = 1'b0;

    // Reads in IDLE are dropped
    cpu_oe = 1'b1; cpu_addr = 12'h005;
    tick; chk("idle_v1", 32'(v1), 0); chk("idle_v2", 32'(v2), 0);
    tick; chk("idle_v1", 32'(v1), 0); chk("idle_v2", 32'(v2), 0);
    cpu_oe = 1'b0;

    // Full load of (i mod 256)
    ld_start = 1'b1; tick; ld_start = 1'b0;
    chk("load_rdy", 32'(rdy1), 1); chk("load_lk", 32'(lk1), 0);
    chk("load_sum0", 32'(sum1), 0);
    done_cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      ld_wr = 1'b1; ld_data = 8'(i); cpu_oe = (i < 8); cpu_addr = 12'(i);
      tick;
      if (done1) done_cnt++;
      if (i < 8) begin
        chk("load_rd_v1", 32'(v1), 0);
        chk("load_rd_v2", 32'(v2), 0);
      end
    end
    ld_wr = 1'b0; cpu_oe = 1'b0;
    chk("done1",    32'(done1), 1); chk("done2", 32'(done2), 1);
    chk("done_cnt", 32'(done_cnt), 1);
    chk("lk1", 32'(lk1), 1); chk("lk2", 32'(lk2), 1); chk("rdy_lk", 32'(rdy1), 0);
    chk("sum1", 32'(sum1), 32'hF800); chk("sum2", 32'(sum2), 32'hF800);

    // Back-to-back reads starting in the first LOCKED cycle
    cpu_oe = 1'b1; cpu_addr = 12'h000; tick;
    chk("done_pulse", 32'(done1), 0);
    chk("r0_v1", 32'(v1), 1); chk("r0_q1", 32'(q1), 32'h00); chk("r0_v2", 32'(v2), 0);
    cpu_addr = 12'h0FF; tick;
    chk("r1_v1", 32'(v1), 1); chk("r1_q1", 32'(q1), 32'hFF);
    chk("r1_v2", 32'(v2), 1); chk("r1_q2", 32'(q2), 32'h00);
    cpu_addr = 12'hFFF; tick;
    chk("r2_v1", 32'(v1), 1); chk("r2_q1", 32'(q1), 32'hFF);
    chk("r2_v2", 32'(v2), 1); chk("r2_q2", 32'(q2), 32'hFF);
    cpu_oe = 1'b0; tick;
    chk("r3_v1", 32'(v1), 0); chk("r3_q1", 32'(q1), 32'hFF);
    chk("r3_v2", 32'(v2), 1); chk("r3_q2", 32'(q2), 32'hFF);
    tick;
    chk("r4_v2", 32'(v2), 0); chk("r4_q2", 32'(q2), 32'hFF);
    cpu_oe = 1'b1; cpu_addr = 12'h123; tick;
    chk("r5_v1", 32'(v1), 1); chk("r5_q1", 32'(q1), 32'h23);
    cpu_oe = 1'b0; tick;
    chk("r6_v1", 32'(v1), 0); chk("r6_q1", 32'(q1), 32'h23);
    chk("r6_v2", 32'(v2), 1); chk("r6_q2", 32'(q2), 32'h23);

    // Load controls are ignored in LOCKED
    ld_start = 1'b1; ld_wr = 1'b1; ld_data = 8'h33; tick;
    ld_start = 1'b0; tick; ld_wr = 1'b0;
    chk("lk_hold", 32'(lk1), 1); chk("lk_rdy", 32'(rdy1), 0);
    chk("lk_sum", 32'(sum1), 32'hF800); chk("lk_done", 32'(done1), 0);
    cpu_oe = 1'b1; cpu_addr = 12'h005; tick;
    chk("lk_q5", 32'(q1), 32'h05);
    cpu_addr = 12'hFFF; tick;
    chk("lk_qfff", 32'(q1), 32'hFF); chk("lk_q5_2", 32'(q2), 32'h05);
    cpu_oe = 1'b0; tick;
    chk("lk_qfff_2", 32'(q2), 32'hFF);

    // Reset with a read in flight
    cpu_oe = 1'b1; cpu_addr = 12'h010; tick;
    chk("fl_v1", 32'(v1), 1); chk("fl_q1", 32'(q1), 32'h10);
    reset = 1'b1; cpu_oe = 1'b0; tick;
    chk("fl_rst_v1", 32'(v1), 0); chk("fl_rst_v2", 32'(v2), 0);
    chk("fl_rst_q1", 32'(q1), 0); chk("fl_rst_q2", 32'(q2), 0);
    chk("fl_rst_lk", 32'(lk1), 0);
    reset = 1'b0; tick;
    chk("fl_v2_after", 32'(v2), 0); chk("fl_idle_rdy", 32'(rdy1), 0);
    chk("fl_idle_lk", 32'(lk1), 0);

    // Restart with coincident ld_wr after 10 writes
    ld_start = 1'b1; tick; ld_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld_wr = 1'b1; ld_data = 8'h11; tick;
    end
    chk("rs_sum10", 32'(sum1), 32'h00AA);
    ld_start = 1'b1; ld_wr = 1'b1; ld_data = 8'hAA; tick;
    ld_start = 1'b0; ld_wr = 1'b0;
    chk("rs_sum1", 32'(sum1), 0); chk("rs_sum2", 32'(sum2), 0);
    chk("rs_ptr", 32'(u_d1.r_wr_ptr), 0);
    chk("rs_mem10", 32'(u_d1.u_mem.r_mem[10]), 32'h0A);
    chk("rs_rdy", 32'(rdy1), 1);

    // Reset at write 2000 abandons the partial image
    for (int i = 0; i < 2000; i++) begin
      ld_wr = 1'b1; ld_data = 8'h77; tick;
    end
    chk("p_sum", 32'(sum1), 32'hA1B0);
    reset = 1'b1; ld_wr = 1'b1; tick;
    reset = 1'b0; ld_wr = 1'b0;
    chk("p_lk", 32'(lk1), 0); chk("p_rdy", 32'(rdy1), 0); chk("p_sum0", 32'(sum1), 0);

    // Full reload of 0x5A
    ld_start = 1'b1; tick; ld_start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      ld_wr = 1'b1; ld_data = 8'h5A; tick;
      if (done1) done_cnt++;
    end
    ld_wr = 1'b0;
    chk("rl_done_cnt", 32'(done_cnt), 1);
    chk("rl_lk1", 32'(lk1), 1); chk("rl_lk2", 32'(lk2), 1);
    chk("rl_sum", 32'(sum1), 32'hA000);

    // Read every address back-to-back
    for (int a = 0; a < 4098; a++) begin
      cpu_oe = (a < 4096); cpu_addr = 12'(a); tick;
      if (a < 4096) begin
        chk("all_v1", 32'(v1), 1); chk("all_q1", 32'(q1), 32'h5A);
      end else begin
        chk("all_v1_end", 32'(v1), 0);
      end
      if (a >= 1 && a < 4097) begin
        chk("all_v2", 32'(v2), 1); chk("all_q2", 32'(q2), 32'h5A);
      end else begin
        chk("all_v2_edge", 32'(v2), 0);
      end
    end
    cpu_oe = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
